// File: rtl/ula_pkg.sv
// ula_pkg: shared op codes, FSM states and default width for controle_ula
package ula_pkg;

    localparam int LARGURA_PADRAO = 8;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_SBC = 2'b01,
        OP_CMP = 2'b10,
        OP_NEG = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        RESULTADO
    } estado_t;

endpackage

// File: rtl/estagio_subtrador.sv
// estagio_subtrador: combinational borrow-ripple subtractor d = x - y - bin
module estagio_subtrador #(
    parameter int LARGURA = 8
) (
    input  logic [LARGURA-1:0] x,
    input  logic [LARGURA-1:0] y,
    input  logic               bin,
    output logic [LARGURA-1:0] d,
    output logic               bout
);

    logic [LARGURA:0] bw;

    assign bw[0] = bin;
    assign bout  = bw[LARGURA];

    for (genvar i = 0; i < LARGURA; i++) begin : g_bit
        assign d[i]    = x[i] ^ y[i] ^ bw[i];
        assign bw[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw[i]);
    end

endmodule

// File: rtl/controle_ula.sv
// controle_ula: handshaked subtract unit (SUB/SBC/CMP/NEG) with flags and chained borrow
module controle_ula
    import ula_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LARGURA-1:0] s,
    output logic               z,
    output logic               n,
    output logic               c,
    output logic               v
);

    localparam int MSB = LARGURA - 1;

    estado_t           estado, prox;
    op_t               op_r;
    logic [LARGURA-1:0] a_r, b_r;
    logic              cb;
    logic [LARGURA-1:0] x, y, d;
    logic              bin, bout;

    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= prox;
    end

    always_comb begin
        prox      = estado;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (estado)
            OCIOSO: begin
                in_ready = 1'b1;
                prox     = in_valid ? CALCULA : OCIOSO;
            end
            CALCULA:   prox = RESULTADO;
            RESULTADO: begin
                out_valid = 1'b1;
                prox      = out_ready ? OCIOSO : RESULTADO;
            end
            default:   prox = OCIOSO;
        endcase
    end

    // NEG reuses the subtractor as 0 - a; only SBC consumes the stored borrow
    always_comb begin
        x   = (op_r == OP_NEG) ? '0 : a_r;
        y   = (op_r == OP_NEG) ? a_r : b_r;
        bin = (op_r == OP_SBC) ? cb : 1'b0;
    end

    estagio_subtrador #(.LARGURA(LARGURA)) u_sub (
        .x    (x),
        .y    (y),
        .bin  (bin),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            op_r <= OP_SUB;
            s    <= '0;
            z    <= 1'b1;
            n    <= 1'b0;
            c    <= 1'b0;
            v    <= 1'b0;
            cb   <= 1'b0;
        end else if (estado == OCIOSO && in_valid) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op_t'(op);
        end else if (estado == CALCULA) begin
            s  <= (op_r == OP_CMP) ? a_r : d;
            z  <= (d == '0);
            n  <= d[MSB];
            c  <= bout;
            v  <= (x[MSB] != y[MSB]) && (d[MSB] != x[MSB]);
            cb <= bout;
        end
    end

endmodule

// File: tb/tb_controle_ula.sv
// tb_controle_ula: directed self-checking bench for controle_ula
module tb_controle_ula;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [1:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] s;
    logic       z, n, c, v;

    int checks = 0;
    int failures = 0;

    controle_ula #(.LARGURA(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .z         (z),
        .n         (n),
        .c         (c),
        .v         (v)
    );

    always #5 clk = ~clk;

    // presents one operand set, returns cycles from presentation to out_valid
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic [1:0] top, output int lat);
        a = ta; b = tb_v; op = top; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks += 7;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (s !== 8'h00)        begin failures++; $display("FAIL reset_s got=%h exp=00", s); end
        if (z !== 1'b1)         begin failures++; $display("FAIL reset_z got=%b exp=1", z); end
        if (n !== 1'b0)         begin failures++; $display("FAIL reset_n got=%b exp=0", n); end
        if (c !== 1'b0)         begin failures++; $display("FAIL reset_c got=%b exp=0", c); end
        if (v !== 1'b0)         begin failures++; $display("FAIL reset_v got=%b exp=0", v); end
    endtask

    task automatic test_sub();
        int lat;
        issue(8'h05, 8'h03, 2'b00, lat);
        checks += 7;
        if (lat !== 2)          begin failures++; $display("FAIL sub_latency got=%0d exp=2", lat); end
        if (in_ready !== 1'b0)  begin failures++; $display("FAIL sub_in_ready got=%b exp=0", in_ready); end
        if (s !== 8'h02)        begin failures++; $display("FAIL sub_s got=%h exp=02", s); end
        if (z !== 1'b0)         begin failures++; $display("FAIL sub_z got=%b exp=0", z); end
        if (n !== 1'b0)         begin failures++; $display("FAIL sub_n got=%b exp=0", n); end
        if (c !== 1'b0)         begin failures++; $display("FAIL sub_c got=%b exp=0", c); end
        if (v !== 1'b0)         begin failures++; $display("FAIL sub_v got=%b exp=0", v); end
        release_result();
        checks++;
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL sub_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_borrow_chain();
        int lat;
        issue(8'h00, 8'h01, 2'b00, lat);
        checks += 3;
        if (s !== 8'hFF) begin failures++; $display("FAIL borrow_s got=%h exp=ff", s); end
        if (c !== 1'b1)  begin failures++; $display("FAIL borrow_c got=%b exp=1", c); end
        if (n !== 1'b1)  begin failures++; $display("FAIL borrow_n got=%b exp=1", n); end
        release_result();
        issue(8'h01, 8'h00, 2'b01, lat);
        checks += 3;
        if (s !== 8'h00) begin failures++; $display("FAIL sbc_s got=%h exp=00", s); end
        if (z !== 1'b1)  begin failures++; $display("FAIL sbc_z got=%b exp=1", z); end
        if (c !== 1'b0)  begin failures++; $display("FAIL sbc_c got=%b exp=0", c); end
        release_result();
    endtask

    task automatic test_flags();
        int lat;
        issue(8'h80, 8'h01, 2'b00, lat);
        checks += 4;
        if (s !== 8'h7F) begin failures++; $display("FAIL ovf_s got=%h exp=7f", s); end
        if (v !== 1'b1)  begin failures++; $display("FAIL ovf_v got=%b exp=1", v); end
        if (n !== 1'b0)  begin failures++; $display("FAIL ovf_n got=%b exp=0", n); end
        if (c !== 1'b0)  begin failures++; $display("FAIL ovf_c got=%b exp=0", c); end
        release_result();
        issue(8'h10, 8'h10, 2'b10, lat);
        checks += 3;
        if (s !== 8'h10) begin failures++; $display("FAIL cmp_s got=%h exp=10", s); end
        if (z !== 1'b1)  begin failures++; $display("FAIL cmp_z got=%b exp=1", z); end
        if (c !== 1'b0)  begin failures++; $display("FAIL cmp_c got=%b exp=0", c); end
        release_result();
        issue(8'h01, 8'h5A, 2'b11, lat);
        checks += 4;
        if (s !== 8'hFF) begin failures++; $display("FAIL neg_s got=%h exp=ff", s); end
        if (c !== 1'b1)  begin failures++; $display("FAIL neg_c got=%b exp=1", c); end
        if (n !== 1'b1)  begin failures++; $display("FAIL neg_n got=%b exp=1", n); end
        if (v !== 1'b0)  begin failures++; $display("FAIL neg_v got=%b exp=0", v); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'h05, 8'h03, 2'b00, lat);
        a = 8'h77; b = 8'h11; op = 2'b00; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks += 4;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
            if (in_ready !== 1'b0)  begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            if (s !== 8'h02)        begin failures++; $display("FAIL bp_s cyc=%0d got=%h exp=02", i, s); end
            if ({z, n, c, v} !== 4'b0000) begin failures++; $display("FAIL bp_flags cyc=%0d got=%b exp=0000", i, {z, n, c, v}); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks += 2;
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL bp_idle_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_idle_out_valid got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0)  begin failures++; $display("FAIL bp_accept_in_ready got=%b exp=0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_second_timeout got=%b exp=1", out_valid); end
        if (s !== 8'h66)        begin failures++; $display("FAIL bp_second_s got=%h exp=66", s); end
        release_result();
        @(posedge clk); #1;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_third got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL bp_final_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic pulse;
        issue(8'h00, 8'h01, 2'b00, lat);
        release_result();
        a = 8'h40; b = 8'h20; op = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pulse |= out_valid;
        end
        checks++;
        if (pulse !== 1'b0)     begin failures++; $display("FAIL rstmid_pulse got=%b exp=0", pulse); end
        issue(8'h05, 8'h03, 2'b01, lat);
        checks += 2;
        if (s !== 8'h02)        begin failures++; $display("FAIL rstmid_sbc_s got=%h exp=02", s); end
        if (c !== 1'b0)         begin failures++; $display("FAIL rstmid_sbc_c got=%b exp=0", c); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_sub();
        test_borrow_chain();
        test_flags();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controle_ula.md
CONTROLE_ULA -- requirements
Module: controle_ula

Interface
REQ-001 The block SHALL have parameter LARGURA, default 8, which sets the operand and result width in bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  LARGURA  minuend operand.
REQ-007 b  input  LARGURA  subtrahend operand.
REQ-008 op  input  2  operation code: 00 SUB, 01 SBC, 10 CMP, 11 NEG.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 s  output  LARGURA  result.
REQ-012 z, n, c, v  output  1 each  flags: zero, negative, borrow, signed overflow.

Function
REQ-013 The FSM SHALL have exactly three states: OCIOSO, CALCULA and RESULTADO.
REQ-014 in_ready SHALL be 1 only in OCIOSO; acceptance occurs on an edge with in_valid=1 and in_ready=1.
REQ-015 On acceptance, a, b and op SHALL be registered and the state SHALL move OCIOSO->CALCULA.
REQ-016 In CALCULA, the registered operands SHALL pass through the subtract stage, s and the flags SHALL be registered, and the state SHALL move to RESULTADO; the stage is unconditional and takes 1 cycle.
REQ-017 out_valid SHALL be 1 exactly in RESULTADO, so it asserts 2 cycles after the accept edge.
REQ-018 The state SHALL move RESULTADO->OCIOSO on an edge with out_ready=1; the next accept can occur 1 cycle later, giving at most 1 operation per 3 cycles.
REQ-019 While out_valid=1 and out_ready=0, s, z, n, c and v SHALL hold stable, and in_valid SHALL be ignored.
REQ-020 SUB SHALL compute a - b with borrow-in 0.
REQ-021 SBC SHALL compute a - b - cb, where cb is the stored borrow register, to support multi-word chaining.
REQ-022 CMP SHALL compute a - b with borrow-in 0, update the flags and cb, and output s = a.
REQ-023 NEG SHALL compute 0 - a with borrow-in 0; b SHALL be ignored.
REQ-024 All arithmetic SHALL be modulo 2^LARGURA; the borrow out of the MSB SHALL drive c.
REQ-025 Flags SHALL be defined as follows:
- z = 1 when the subtraction result is all zeros (for CMP, the difference, not s);
- n = MSB of the difference;
- v = (minuend MSB != subtrahend MSB) AND (difference MSB != minuend MSB), using the NEG operands 0 and a for NEG.
REQ-026 cb SHALL be loaded with c at every CALCULA edge and SHALL hold otherwise.
REQ-027 in_valid held high across RESULTADO SHALL NOT cause a double accept; capture occurs only in OCIOSO.

Reset
REQ-028 With rst=1 on an edge:
- the state SHALL go to OCIOSO;
- s SHALL be 0, z SHALL be 1, and n, c, v and cb SHALL be 0;
- out_valid SHALL be 0 and in_ready SHALL be 1 from the next cycle.
REQ-029 Reset SHALL take priority over any handshake on the same edge.
REQ-030 Reset in CALCULA or RESULTADO SHALL discard the operation, with no out_valid pulse.

Structure
REQ-031 Package ula_pkg SHALL hold the op enum (OP_SUB, OP_SBC, OP_CMP, OP_NEG), the FSM state enum and the default LARGURA.
REQ-032 The block SHALL have one combinational sub-module, estagio_subtrador (LARGURA-bit borrow-ripple, inputs x, y, bin, outputs d, bout), instantiated once; operand muxing and flag logic SHALL be in controle_ula.

Verification
REQ-033 SUB a=0x05, b=0x03 -> out_valid 2 cycles after accept; s=0x02, z=0, n=0, c=0, v=0.
REQ-034 SUB 0x00-0x01 -> s=0xFF, c=1, n=1; then SBC 0x01-0x00 -> s=0x00, z=1, c=0.
REQ-035 SUB 0x80-0x01 -> s=0x7F, v=1, n=0, c=0; CMP 0x10 vs 0x10 -> s=0x10, z=1, c=0; NEG a=0x01 -> s=0xFF, c=1, n=1.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in RESULTADO with in_valid=1 -> s and flags stable, in_ready=0, no second accept; out_ready=1 -> OCIOSO, then a single new accept.
REQ-037 After SUB 0x00-0x01 sets cb=1, assert rst during the CALCULA of the next operation -> no out_valid pulse, in_ready=1 the next cycle, cb=0; a following SBC 0x05-0x03 gives s=0x02.
